// File: rtl/redmule_z_drain_buffer.sv
// Ping-pong drain buffer: collects result columns from the array and emits one row per beat.
// Optional stall/overflow counters are enabled by defining REDMULE_Z_DRAIN_STALL_CNT_EN.
module redmule_z_drain_buffer #(
    parameter int unsigned DW     = 288,
    parameter int unsigned BITW   = 16,
    parameter int unsigned Height = 4,
    parameter int unsigned Width  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic [$clog2(Width):0]        width_i,
    input  logic [$clog2(Height):0]       height_i,
    input  logic [Width*BITW-1:0]         z_i,
    input  logic                          z_valid_i,
    output logic                          z_ready_o,
    output logic [DW-1:0]                 z_o,
    output logic [DW/8-1:0]               z_strb_o,
    output logic                          z_valid_o,
    input  logic                          z_ready_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          tile_done_o
`ifdef REDMULE_Z_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt_o,
    output logic [31:0]                   ovf_cnt_o
`endif
);

    localparam int unsigned WW  = $clog2(Width) + 1;
    localparam int unsigned HW  = $clog2(Height) + 1;
    localparam int unsigned HIW = (Height > 1) ? $clog2(Height) : 1;
    localparam int unsigned RIW = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned SW  = DW / 8;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    bank_state_e         state_reg  [2];
    bank_state_e         state_next [2];
    logic [WW-1:0]       width_reg  [2];
    logic [WW-1:0]       width_next [2];
    logic [HW-1:0]       height_reg [2];
    logic [HW-1:0]       height_next[2];
    logic                wr_bank_reg, wr_bank_next;
    logic                rd_bank_reg, rd_bank_next;
    logic [HIW-1:0]      h_idx_reg, h_idx_next;
    logic [RIW-1:0]      row_idx_reg, row_idx_next;
    logic [BITW-1:0]     mem_reg [2][Height][Width];

    logic                capture, drain, last_col, last_row;
    logic [HW-1:0]       cap_height, rd_height;
    logic [WW-1:0]       rd_width;
    logic [DW-1:0]       z_row;

    function automatic logic [WW-1:0] clamp_w(input logic [WW-1:0] v);
        if (v == '0) return WW'(1);
        if (v > WW'(Width)) return WW'(Width);
        return v;
    endfunction

    function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] v);
        if (v == '0) return HW'(1);
        if (v > HW'(Height)) return HW'(Height);
        return v;
    endfunction

    // Ready depends only on registered bank state, so a freed bank is writable the next cycle.
    assign z_ready_o = (state_reg[wr_bank_reg] == EMPTY) || (state_reg[wr_bank_reg] == FILLING);
    assign z_valid_o = (state_reg[rd_bank_reg] == FULL) || (state_reg[rd_bank_reg] == DRAINING);
    assign capture   = z_valid_i && z_ready_o;
    assign drain     = z_valid_o && z_ready_i;

    // The first column of a tile must already see the clamped size it is about to latch.
    assign cap_height = (state_reg[wr_bank_reg] == EMPTY) ? clamp_h(height_i) : height_reg[wr_bank_reg];
    assign rd_width   = width_reg[rd_bank_reg];
    assign rd_height  = height_reg[rd_bank_reg];
    assign last_col   = (HW'(h_idx_reg) == cap_height - HW'(1));
    assign last_row   = (WW'(row_idx_reg) == rd_width - WW'(1));

    assign tile_done_o = drain && last_row;
    assign full_o      = (state_reg[0] == FULL) && (state_reg[1] == FULL);
    assign empty_o     = (state_reg[0] == EMPTY) && (state_reg[1] == EMPTY);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b]  = state_reg[b];
            width_next[b]  = width_reg[b];
            height_next[b] = height_reg[b];
        end
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        h_idx_next   = h_idx_reg;
        row_idx_next = row_idx_reg;

        if (capture) begin
            if (state_reg[wr_bank_reg] == EMPTY) begin
                width_next[wr_bank_reg]  = clamp_w(width_i);
                height_next[wr_bank_reg] = clamp_h(height_i);
            end
            if (last_col) begin
                state_next[wr_bank_reg] = FULL;
                h_idx_next              = '0;
                wr_bank_next            = ~wr_bank_reg;
            end else begin
                state_next[wr_bank_reg] = FILLING;
                h_idx_next              = h_idx_reg + 1'b1;
            end
        end

        // Capture and drain never target the same bank, so these updates cannot collide.
        if (drain) begin
            if (last_row) begin
                state_next[rd_bank_reg] = EMPTY;
                row_idx_next            = '0;
                rd_bank_next            = ~rd_bank_reg;
            end else begin
                state_next[rd_bank_reg] = DRAINING;
                row_idx_next            = row_idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b]  <= EMPTY;
                width_reg[b]  <= '0;
                height_reg[b] <= '0;
            end
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            h_idx_reg   <= '0;
            row_idx_reg <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b]  <= state_next[b];
                width_reg[b]  <= width_next[b];
                height_reg[b] <= height_next[b];
            end
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            h_idx_reg   <= h_idx_next;
            row_idx_reg <= row_idx_next;
        end
    end

    for (genvar gi = 0; gi < Width; gi++) begin : g_store
        always_ff @(posedge clk_i) begin
            if (rst_ni && !clear_i && capture) begin
                mem_reg[wr_bank_reg][h_idx_reg][gi] <= z_i[gi*BITW +: BITW];
            end
        end
    end

    // Column gi of the current row; columns past the tile height read as zero.
    for (genvar gi = 0; gi < Height; gi++) begin : g_row
        assign z_row[gi*BITW +: BITW] = (z_valid_o && (HW'(gi) < rd_height))
                                        ? mem_reg[rd_bank_reg][gi][row_idx_reg] : '0;
    end
    if (DW > Height * BITW) begin : g_pad
        assign z_row[DW-1:Height*BITW] = '0;
    end
    assign z_o = z_row;

    for (genvar gi = 0; gi < SW; gi++) begin : g_strb
        assign z_strb_o[gi] = z_valid_o && ((32'(gi) * 32'd8) < (32'(rd_height) * 32'(BITW)));
    end

`ifdef REDMULE_Z_DRAIN_STALL_CNT_EN
    logic [31:0] stall_cnt_reg, ovf_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            stall_cnt_reg <= '0;
            ovf_cnt_reg   <= '0;
        end else begin
            if (z_valid_o && !z_ready_i && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (z_valid_i && !z_ready_o && (ovf_cnt_reg != '1)) ovf_cnt_reg <= ovf_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign ovf_cnt_o   = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_redmule_z_drain_buffer.sv
// Scoreboard bench for redmule_z_drain_buffer (H=W=4, 16-bit elements, DW=288).
module tb_redmule_z_drain_buffer;

    logic         clk;
    logic         rst_ni;
    logic         clear_i;
    logic [2:0]   width_i;
    logic [2:0]   height_i;
    logic [63:0]  z_i;
    logic         z_valid_i;
    logic         z_ready_o;
    logic [287:0] z_o;
    logic [35:0]  z_strb_o;
    logic         z_valid_o;
    logic         z_ready_i;
    logic         full_o;
    logic         empty_o;
    logic         tile_done_o;
`ifdef REDMULE_Z_DRAIN_STALL_CNT_EN
    logic [31:0]  stall_cnt_o;
    logic [31:0]  ovf_cnt_o;
`endif

    redmule_z_drain_buffer #(
        .DW(288), .BITW(16), .Height(4), .Width(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .width_i(width_i), .height_i(height_i),
        .z_i(z_i), .z_valid_i(z_valid_i), .z_ready_o(z_ready_o),
        .z_o(z_o), .z_strb_o(z_strb_o), .z_valid_o(z_valid_o), .z_ready_i(z_ready_i),
        .full_o(full_o), .empty_o(empty_o), .tile_done_o(tile_done_o)
`ifdef REDMULE_Z_DRAIN_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .ovf_cnt_o(ovf_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [287:0] data;
        logic [35:0]  strb;
        logic         last;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          beat_no = 0;

    logic [63:0] m_cols[4];
    int          m_cnt = 0;
    int          m_w = 1;
    int          m_h = 1;

    function automatic int clamp4(input int v);
        if (v == 0) return 1;
        if (v > 4) return 4;
        return v;
    endfunction

    // Column c of a tile: element w holds base + 4*c + w.
    function automatic logic [63:0] col(input int base, input int c);
        logic [63:0] r;
        for (int w = 0; w < 4; w++) r[w*16 +: 16] = 16'(base + 4 * c + w);
        return r;
    endfunction

    // Monitor: models accepted captures into expected rows and checks every output beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_ni || clear_i) begin
                sb_q.delete();
                m_cnt = 0;
            end else begin
                if (z_valid_o === 1'b1 && z_ready_i === 1'b1) begin
                    vectors++;
                    if (sb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_beat: got z_o=%h, want no beat", z_o);
                    end else begin
                        e = sb_q.pop_front();
                        beat_no++;
                        $display("beat %0d: z_o[63:0]=%h strb=%h done=%b", beat_no, z_o[63:0], z_strb_o, tile_done_o);
                        if (z_o !== e.data || z_strb_o !== e.strb || tile_done_o !== e.last) begin
                            miscompares++;
                            $display("FAIL beat_%0d: got z_o=%h strb=%h done=%b, want z_o=%h strb=%h done=%b",
                                     beat_no, z_o, z_strb_o, tile_done_o, e.data, e.strb, e.last);
                        end
                    end
                end else if (tile_done_o !== 1'b0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_tile_done: got %b, want 0", tile_done_o);
                end
                if (z_valid_i === 1'b1 && z_ready_o === 1'b1) begin
                    if (m_cnt == 0) begin
                        m_w = clamp4(int'(width_i));
                        m_h = clamp4(int'(height_i));
                    end
                    m_cols[m_cnt] = z_i;
                    m_cnt++;
                    if (m_cnt == m_h) begin
                        for (int r = 0; r < m_w; r++) begin
                            e.data = '0;
                            e.strb = '0;
                            for (int h = 0; h < m_h; h++) e.data[h*16 +: 16] = m_cols[h][r*16 +: 16];
                            for (int b = 0; b < 36; b++) e.strb[b] = (b * 8 < m_h * 16);
                            e.last = (r == m_w - 1);
                            sb_q.push_back(e);
                        end
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] z, input logic rdy);
        @(negedge clk);
        z_valid_i = v;
        z_i       = z;
        z_ready_i = rdy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_ni = 1'b0; z_valid_i = 1'b1; z_i = col(16'h700, 0); z_ready_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1; z_valid_i = 1'b0;
        #1;
        vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", z_valid_o); end
        vectors++; if (z_o !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", z_o); end
        vectors++; if (z_strb_o !== '0) begin miscompares++; $display("FAIL reset_strb: got %h want 0", z_strb_o); end
        vectors++; if (tile_done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", tile_done_o); end
        vectors++; if (full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full_o); end
        vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty_o); end
        vectors++; if (z_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", z_ready_o); end
    endtask

    task automatic test_full_tile();
        width_i = 3'd4; height_i = 3'd4;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, col(1, c), 1'b1);
            #1;
            vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL full_pre_valid_%0d: got %b want 0", c, z_valid_o); end
        end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL full_first_valid: got %b want 1", z_valid_o); end
        vectors++; if (z_o[63:0] !== 64'h000D_0009_0005_0001) begin miscompares++; $display("FAIL full_row0: got %h want 000d000900050001", z_o[63:0]); end
        vectors++; if (z_strb_o !== 36'h0_0000_00FF) begin miscompares++; $display("FAIL full_strb: got %h want 0ff", z_strb_o); end
        for (int b = 1; b < 4; b++) begin
            drive(1'b0, '0, 1'b1);
            #1;
            vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL full_valid_beat%0d: got %b want 1", b + 1, z_valid_o); end
        end
        vectors++; if (tile_done_o !== 1'b1) begin miscompares++; $display("FAIL full_done_beat4: got %b want 1", tile_done_o); end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b0 || empty_o !== 1'b1) begin miscompares++; $display("FAIL full_after: got valid=%b empty=%b want 0 1", z_valid_o, empty_o); end
    endtask

    task automatic test_leftover();
        width_i = 3'd2; height_i = 3'd3;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, col(16'h100, c), 1'b1);
            if (c == 1) begin width_i = 3'd4; height_i = 3'd4; end
            #1;
            vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL left_pre_valid_%0d: got %b want 0", c, z_valid_o); end
        end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL left_valid: got %b want 1", z_valid_o); end
        vectors++; if (z_strb_o !== 36'h3F) begin miscompares++; $display("FAIL left_strb: got %h want 3f", z_strb_o); end
        vectors++; if (z_o[287:48] !== '0) begin miscompares++; $display("FAIL left_pad: got %h want 0", z_o[287:48]); end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL left_valid2: got %b want 1", z_valid_o); end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL left_two_beats: got %b want 0", z_valid_o); end
    endtask

    task automatic test_clamp();
        width_i = 3'd0; height_i = 3'd7;
        for (int c = 0; c < 4; c++) drive(1'b1, col(16'h180, c), 1'b1);
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL clamp_valid: got %b want 1", z_valid_o); end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL clamp_one_beat: got %b want 0", z_valid_o); end
        width_i = 3'd4; height_i = 3'd4;
    endtask

    task automatic test_backpressure();
        logic [287:0] held;
        for (int c = 0; c < 8; c++) drive(1'b1, col((c < 4) ? 16'h200 : 16'h300, c % 4), 1'b0);
        drive(1'b1, col(16'h900, 0), 1'b0);
        #1;
        vectors++; if (full_o !== 1'b1) begin miscompares++; $display("FAIL bp_full: got %b want 1", full_o); end
        vectors++; if (z_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b want 0", z_ready_o); end
        vectors++; if (z_o[63:0] !== 64'h020C_0208_0204_0200) begin miscompares++; $display("FAIL bp_row0: got %h want 020c020802040200", z_o[63:0]); end
        held = z_o;
        drive(1'b1, col(16'h900, 0), 1'b0);
        drive(1'b1, col(16'h900, 0), 1'b0);
        #1;
        vectors++; if (z_o !== held || z_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_stable: got %h/%b want %h/1", z_o, z_valid_o, held); end
        for (int b = 0; b < 8; b++) begin
            drive(1'b0, '0, 1'b1);
            #1;
            vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_drain_valid%0d: got %b want 1", b, z_valid_o); end
        end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL bp_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive(i < 12, (i < 12) ? col(16'h1000 + (i / 4) * 16'h100, i % 4) : 64'h0, 1'b1);
            #1;
            if (i >= 4) begin
                vectors++; if (z_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_bubble_%0d: got %b want 1", i, z_valid_o); end
            end
            if (i >= 1) begin
                vectors++; if (empty_o !== 1'b0) begin miscompares++; $display("FAIL b2b_empty_%0d: got %b want 0", i, empty_o); end
            end
        end
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (empty_o !== 1'b1 || z_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got empty=%b valid=%b want 1 0", empty_o, z_valid_o); end
    endtask

    task automatic test_clear();
        for (int c = 0; c < 4; c++) drive(1'b1, col(16'h400, c), 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL clr_valid: got %b want 0", z_valid_o); end
        vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL clr_empty: got %b want 1", empty_o); end
        vectors++; if (z_ready_o !== 1'b1) begin miscompares++; $display("FAIL clr_ready: got %b want 1", z_ready_o); end
        width_i = 3'd2; height_i = 3'd2;
        for (int c = 0; c < 2; c++) drive(1'b1, col(16'h500, c), 1'b1);
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_o[31:0] !== 32'h0504_0500) begin miscompares++; $display("FAIL clr_row0: got %h want 05040500", z_o[31:0]); end
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        #1;
        vectors++; if (z_valid_o !== 1'b0) begin miscompares++; $display("FAIL clr_done: got %b want 0", z_valid_o); end
        width_i = 3'd4; height_i = 3'd4;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; z_valid_i = 1'b0; z_ready_i = 1'b0;
        z_i = '0; width_i = 3'd4; height_i = 3'd4;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        test_reset();
        test_full_tile();
        test_leftover();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_clear();
        drive(1'b0, '0, 1'b1);
        #3;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drained: got %0d rows pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/redmule_z_drain_buffer.md
Name: redmule_z_drain_buffer

Overview:
- Output-side counterpart to the X input buffer. Collects result columns from the engine array and serializes them, one row per beat, onto a DW-wide valid/ready stream toward the store streamer.
- Two banks (ping-pong): the array fills one tile while the other drains.
- Columns and rows beyond the programmed leftover tile size are zero-padded or skipped.

Parameters:
- DW, 288, stream data width in bits; H*BITW <= DW.
- FpFormat, fpnew_pkg::FP16, element format; BITW = fpnew_pkg::fp_width(FpFormat).
- Height, ARRAY_HEIGHT, H = columns per tile (elements per output row).
- Width, ARRAY_WIDTH, W = rows per tile (array outputs per capture).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- width_i  in  $clog2(W)+1  valid rows of the tile being filled (1..W).
- height_i  in  $clog2(H)+1  valid columns of the tile being filled (1..H).
- z_i  in  W*BITW  one result column; element w sits at [w*BITW +: BITW].
- z_valid_i  in  1  capture request for z_i.
- z_ready_o  out  1  capture accepted when z_valid_i & z_ready_o.
- z_o  out  DW  output row.
- z_strb_o  out  DW/8  byte strobe for z_o.
- z_valid_o  out  1  output row valid.
- z_ready_i  in  1  downstream accept.
- full_o  out  1  both banks FULL.
- empty_o  out  1  both banks EMPTY.
- tile_done_o  out  1  one-cycle pulse on the final row handshake of a tile.

Behaviour:
- Reset or clear_i:
  - Banks go to EMPTY; wr_bank = rd_bank = 0; h_idx = row_idx = 0.
  - Outputs: z_valid_o = 0, z_o = 0, z_strb_o = 0, tile_done_o = 0, full_o = 0, empty_o = 1, z_ready_o = 1.
  - clear_i takes priority over any simultaneous handshake; the register state after that edge equals the reset state.
- Per-bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Bank storage: H x W x BITW registers.
- Bank latches width_i and height_i on its first capture (EMPTY -> FILLING). Later changes to the ports do not affect that tile.
- Out-of-range size values are clamped: 0 becomes 1; values above W or H become W or H.
- Capture:
  - z_ready_o = wr bank is EMPTY or FILLING.
  - On each handshake, z_i is written to column h_idx of the wr bank and h_idx increments.
  - When the handshake hits h_idx == height-1: bank -> FULL, h_idx -> 0, wr_bank toggles.
  - When both banks are FULL or DRAINING, z_ready_o = 0.
- Drain:
  - z_valid_o = 1 when the rd bank is FULL or DRAINING. First beat moves the bank FULL -> DRAINING.
  - z_o for row r: element h (column h of row r) at [h*BITW +: BITW] for h < height; 0 for h >= height; bits [DW-1:H*BITW] are 0.
  - z_strb_o: low ceil(height*BITW/8) bits set, rest 0.
  - On handshake, row_idx increments.
  - On the handshake with row_idx == width-1: bank -> EMPTY, row_idx -> 0, rd_bank toggles, tile_done_o = 1 for one cycle.
  - z_o, z_strb_o and z_valid_o are held stable while z_valid_o & ~z_ready_i.
- Latency:
  - The capture that completes a tile at edge t makes z_valid_o high in the cycle after t.
  - With z_ready_i held high, a tile drains in exactly width cycles.
  - With continuous input and output, throughput is one tile per max(height, width) cycles; there are no bubbles between tiles.
- Simultaneous events:
  - A capture into one bank and a drain of the other are independent in the same cycle.
  - The final drain beat of bank A in the same cycle as a capture into A is impossible: A is not writable while DRAINING.
  - A bank freed at edge t is writable from cycle t+1 (z_ready_o is registered-state based, no combinational ready-to-ready path).
- Wrap: bank pointers are 1 bit and wrap 1 -> 0.
- Flags: full_o and empty_o are combinational from bank states.

Optional Feature:
- Macro: REDMULE_Z_DRAIN_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 32 bits: counts cycles with z_valid_o & ~z_ready_i.
  - Adds output ovf_cnt_o, 32 bits: counts cycles with z_valid_i & ~z_ready_o.
  - Both saturate at 2^32-1 and clear on reset and clear_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Full tile: H=W=4, FP16, width=4, height=4, capture columns with values 0x0001..0x0010, z_ready_i=1 -> 4 rows out on consecutive cycles starting the cycle after the 4th capture. Row 0 elements = 0x0001, 0x0005, 0x0009, 0x000D; z_strb_o low 8 bits set; tile_done_o pulses on beat 4.
- Leftover tile: width=2, height=3 -> exactly 2 beats; element 3 and bits above 48 are 0; z_strb_o = 0x3F; the third capture completes the tile.
- Backpressure: fill 2 tiles with z_ready_i=0 -> full_o=1 and z_ready_o=0; a 3rd z_valid_i is stalled. z_o stays stable; release z_ready_i -> 8 beats in order bank0 then bank1.
- Ping-pong overlap: continuous captures with z_ready_i=1 -> no idle cycle on z_valid_o across 3 tiles; empty_o=1 only after the last tile_done_o.
- clear_i mid-drain after beat 2 -> next cycle z_valid_o=0, empty_o=1, z_ready_o=1; the next tile starts at row 0 in bank 0.
- rst_ni low for 1 cycle with z_valid_i=1 -> the capture is ignored and all outputs hold their reset values.
